// File: rtl/fifo_rr_arbiter.sv
// Round-robin read arbiter: shares one downstream serializer port between
// NUM_REQ ingress frame FIFOs. One FIFO is granted at a time and read in a
// burst of single-cycle rd_en pulses (at most one frame every two cycles).
// A burst ends on a last-of-packet frame, on the burst limit, when the FIFO
// runs empty, or when the serializer stays busy for STALL_MAX cycles.
//
// Handshake: a frame transfers in exactly the cycle rd_en[grant_id] is high.
// rd_en is raised only when the granted FIFO is not empty (its valid) and
// sw_busy is low (downstream ready); nothing else is qualified by it.
module fifo_rr_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int IDX_W     = 3,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3,
  parameter int STALL_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] empty,
  input  logic [NUM_REQ-1:0] last,
  input  logic               sw_busy,
  output logic [NUM_REQ-1:0] rd_en,
  output logic               grant_vld,
  output logic [IDX_W-1:0]   grant_id,
  output logic [CNT_W-1:0]   burst_cnt,
  output logic               rel_pulse,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    READ = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [7:0]         stall_q;
  logic               last_q;

  // Decoded control from the next-state logic
  logic               do_grant;
  logic               do_pulse;
  logic               do_stall;
  logic               do_release;

  // Round-robin search result
  logic               found;
  logic [IDX_W-1:0]   pick;

  // Head-of-FIFO flags of the currently granted requester
  logic               gnt_empty;
  logic               gnt_last;

  assign gnt_empty = empty[grant_id];
  assign gnt_last  = last[grant_id];
  assign fsm_state = state_q;

  // Search ptr+1, ptr+2, ... (mod NUM_REQ) for the first non-empty FIFO,
  // so the most recently granted FIFO is always considered last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j;
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && !empty[j]) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    do_pulse   = 1'b0;
    do_stall   = 1'b0;
    do_release = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|(~empty)) && !sw_busy) begin
          state_d = ARB;
        end
      end
      ARB: begin
        // Requests may have drained since IDLE saw them; then back off quietly.
        if (found) begin
          do_grant = 1'b1;
          state_d  = READ;
        end else begin
          state_d  = IDLE;
        end
      end
      READ: begin
        if (!sw_busy) begin
          if (!gnt_empty) begin
            do_pulse = 1'b1;
            state_d  = GAP;
          end else begin
            do_release = 1'b1;
            state_d    = IDLE;
          end
        end else if (stall_q == 8'(STALL_MAX - 1)) begin
          // This busy cycle is the STALL_MAX-th in a row: give up the grant.
          do_release = 1'b1;
          state_d    = IDLE;
        end else begin
          do_stall = 1'b1;
        end
      end
      GAP: begin
        // empty has settled after the previous read; any reason ends the burst once.
        if (last_q || (burst_cnt == CNT_W'(MAX_BURST)) || gnt_empty) begin
          do_release = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d    = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read pulse to the granted FIFO only, in the transfer cycle
  always_comb begin
    rd_en = '0;
    if (do_pulse) begin
      rd_en[grant_id] = 1'b1;
    end
  end

  // Grant, burst and stall bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      grant_vld <= 1'b0;
      grant_id  <= '0;
      burst_cnt <= '0;
      rel_pulse <= 1'b0;
      stall_q   <= '0;
      last_q    <= 1'b0;
    end else begin
      rel_pulse <= do_release;
      if (do_grant) begin
        grant_id  <= pick;
        grant_vld <= 1'b1;
        burst_cnt <= '0;
        stall_q   <= '0;
        last_q    <= 1'b0;
      end
      if (do_pulse) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
        last_q    <= gnt_last;
        stall_q   <= '0;
      end
      if (do_stall) begin
        stall_q <= stall_q + 8'd1;
      end
      if (do_release) begin
        // burst_cnt is left alone so the finished burst length stays visible.
        ptr_q     <= grant_id;
        grant_vld <= 1'b0;
        stall_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: a behavioural FIFO bank feeds the
// arbiter, a monitor logs every read pulse and release, and one task per
// scenario checks cycle-exact outputs against hand-derived values.
module tb_fifo_rr_arbiter;

  localparam int NUM_REQ   = 5;
  localparam int IDX_W     = 3;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 3;
  localparam int STALL_MAX = 15;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] last;
  logic               sw_busy;
  logic [NUM_REQ-1:0] rd_en;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_id;
  logic [CNT_W-1:0]   burst_cnt;
  logic               rel_pulse;
  logic [1:0]         fsm_state;

  // FIFO bank model: frame count, last flag on final frame, endless refill
  int                 cnt[NUM_REQ];
  bit                 last_end[NUM_REQ];
  bit                 refill[NUM_REQ];
  logic [NUM_REQ-1:0] rd_q;

  // Monitor logs
  logic [IDX_W-1:0]   pulse_q[$];
  logic [CNT_W-1:0]   rel_bc[$];
  logic [IDX_W-1:0]   exp_q[$];
  int                 rel_count;
  int                 viol;

  int                 n_cmp;
  int                 n_fail;

  fifo_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .MAX_BURST(MAX_BURST),
    .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk), .rst(rst), .empty(empty), .last(last), .sw_busy(sw_busy),
    .rd_en(rd_en), .grant_vld(grant_vld), .grant_id(grant_id),
    .burst_cnt(burst_cnt), .rel_pulse(rel_pulse), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // FIFO flags derived from the model contents
  always_comb begin
    empty = '0;
    last  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      empty[i] = (cnt[i] == 0);
      last[i]  = last_end[i] && (refill[i] || cnt[i] == 1);
    end
  end

  // Pop a frame just after the edge that ends a read cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rd_q[i] && !refill[i] && cnt[i] > 0) cnt[i] = cnt[i] - 1;
      end
      rd_q = '0;
    end
  end

  // Monitor: log pulses and releases, flag illegal read pulses
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        rd_q = rd_en;
        if (rd_en != '0) begin
          if (!$onehot(rd_en) || fsm_state != 2'd2 || (rd_en & empty) != '0) viol++;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_en[i]) pulse_q.push_back(IDX_W'(i));
          end
        end
        if (rel_pulse) begin
          rel_count++;
          rel_bc.push_back(burst_cnt);
        end
      end else begin
        rd_q = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    sw_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0; last_end[i] = 1'b0; refill[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_q.delete();
    rel_bc.delete();
    rel_count = 0;
  endtask

  task automatic wait_pulses(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #3;
      if (pulse_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst     = 1'b1;
    sw_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt[i] = 0; last_end[i] = 1'b0; refill[i] = 1'b0;
    end
    rd_q = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({rd_en, grant_vld, grant_id, burst_cnt, rel_pulse, fsm_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rd_en=%b vld=%b id=%0d bc=%0d rel=%b st=%0d required all 0",
               rd_en, grant_vld, grant_id, burst_cnt, rel_pulse, fsm_state);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (fsm_state !== 2'd0 || grant_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: st=%0d vld=%b required st=0 vld=0", fsm_state, grant_vld);
    end
  endtask

  task automatic test_two_frames();
    logic [NUM_REQ-1:0] t_rd[7];
    logic               t_vld[7];
    t_rd  = '{5'b00000, 5'b00100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
    t_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    @(negedge clk);
    cnt[2] = 2; last_end[2] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (rd_en !== t_rd[k] || grant_vld !== t_vld[k]) begin
        n_fail++;
        $display("FAIL two_frames cyc%0d: rd_en=%b vld=%b required rd_en=%b vld=%b",
                 k + 1, rd_en, grant_vld, t_rd[k], t_vld[k]);
      end
      if (k == 1) begin
        n_cmp++;
        if (grant_id !== 3'd2) begin
          n_fail++;
          $display("FAIL two_frames_id: grant_id=%0d required 2", grant_id);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (rel_pulse !== 1'b1 || burst_cnt !== 3'd2) begin
          n_fail++;
          $display("FAIL two_frames_rel: rel=%b bc=%0d required rel=1 bc=2", rel_pulse, burst_cnt);
        end
      end
      if (k == 6) begin
        n_cmp++;
        if (rel_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL two_frames_rel_width: rel=%b required 0", rel_pulse);
        end
      end
    end
  endtask

  task automatic test_rotation();
    bit ok;
    apply_reset();
    @(negedge clk);
    foreach (cnt[i]) begin
      if (i == 0 || i == 1 || i == 3) begin
        cnt[i] = 1; refill[i] = 1'b1; last_end[i] = 1'b1;
      end
    end
    exp_q = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3};
    wait_pulses(6, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rotation_timeout: pulses=%0d required 6", pulse_q.size());
    end
    n_cmp++;
    if (rel_count !== 5) begin
      n_fail++;
      $display("FAIL rotation_one_per_grant: releases=%0d required 5", rel_count);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (pulse_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rotation_order[%0d]: id=%0d required %0d", i, pulse_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_burst_limit();
    bit ok;
    logic [CNT_W-1:0] exp_bc[5];
    exp_bc = '{3'd4, 3'd1, 3'd1, 3'd4, 3'd2};
    apply_reset();
    @(negedge clk);
    cnt[4] = 10;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #3;
      if (grant_vld && grant_id == 3'd4) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL burst_first_grant: grant_id=%0d vld=%b required id=4 vld=1", grant_id, grant_vld);
    end
    cnt[1] = 1; last_end[1] = 1'b1;
    cnt[2] = 1; last_end[2] = 1'b1;
    exp_q = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    wait_pulses(12, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL burst_timeout: pulses=%0d required 12", pulse_q.size());
    end
    repeat (6) @(negedge clk);
    #3;
    n_cmp++;
    if (pulse_q.size() !== 12 || rel_count !== 5 || cnt[4] !== 0) begin
      n_fail++;
      $display("FAIL burst_totals: pulses=%0d rels=%0d left=%0d required 12 5 0",
               pulse_q.size(), rel_count, cnt[4]);
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (pulse_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL burst_order[%0d]: id=%0d required %0d", i, pulse_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rel_bc[i] !== exp_bc[i]) begin
        n_fail++;
        $display("FAIL burst_len[%0d]: bc=%0d required %0d", i, rel_bc[i], exp_bc[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit bad;
    apply_reset();
    @(negedge clk);
    cnt[1] = 3;
    @(negedge clk);
    #1;
    n_cmp++;
    if (fsm_state !== 2'd1) begin
      n_fail++;
      $display("FAIL stall_arb_state: st=%0d required 1", fsm_state);
    end
    sw_busy = 1'b1;
    bad = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (rd_en !== '0 || grant_vld !== 1'b1 || grant_id !== 3'd1 || rel_pulse !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL stall_hold: grant lost or read during busy, last rd_en=%b vld=%b required rd_en=0 vld=1",
               rd_en, grant_vld);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (rel_pulse !== 1'b1 || grant_vld !== 1'b0 || burst_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL stall_release: rel=%b vld=%b bc=%0d required rel=1 vld=0 bc=0",
               rel_pulse, grant_vld, burst_cnt);
    end
    cnt[2] = 1; last_end[2] = 1'b1;
    repeat (4) @(negedge clk);
    sw_busy = 1'b0;
    n_cmp++;
    if (pulse_q.size() !== 0) begin
      n_fail++;
      $display("FAIL stall_no_read: pulses=%0d required 0", pulse_q.size());
    end
    wait_pulses(1, 20, ok);
    n_cmp++;
    if (!ok || pulse_q[0] !== 3'd2) begin
      n_fail++;
      $display("FAIL stall_ptr: first id=%0d required 2", pulse_q[0]);
    end

    // Short busy run: the burst continues without a release.
    apply_reset();
    @(negedge clk);
    cnt[1] = 3;
    @(negedge clk);
    #1;
    sw_busy = 1'b1;
    bad = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      #1;
      if (rd_en !== '0 || grant_vld !== 1'b1) bad = 1'b1;
    end
    @(negedge clk);
    sw_busy = 1'b0;
    #1;
    n_cmp++;
    if (bad || rd_en !== 5'b00010) begin
      n_fail++;
      $display("FAIL short_busy_resume: rd_en=%b bad=%b required rd_en=00010 bad=0", rd_en, bad);
    end
    wait_pulses(3, 20, ok);
    repeat (4) @(negedge clk);
    #3;
    n_cmp++;
    if (!ok || rel_count !== 1 || rel_bc[0] !== 3'd3) begin
      n_fail++;
      $display("FAIL short_busy_burst: rels=%0d bc=%0d required 1 3", rel_count, rel_bc[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    apply_reset();
    @(negedge clk);
    cnt[3] = 3;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (rd_en !== 5'b01000) begin
      n_fail++;
      $display("FAIL midrst_read: rd_en=%b required 01000", rd_en);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (fsm_state !== 2'd3) begin
      n_fail++;
      $display("FAIL midrst_gap: st=%0d required 3", fsm_state);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rd_en, grant_vld, grant_id, burst_cnt, rel_pulse} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: rd_en=%b vld=%b id=%0d bc=%0d rel=%b required all 0",
               rd_en, grant_vld, grant_id, burst_cnt, rel_pulse);
    end
    cnt[0] = 1; last_end[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_q.delete();
    exp_q = '{3'd0, 3'd3};
    wait_pulses(2, 30, ok);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (!ok || pulse_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_restart[%0d]: id=%0d required %0d", i, pulse_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_arb_empty();
    bit bad;
    apply_reset();
    @(negedge clk);
    cnt[0] = 1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (fsm_state !== 2'd1) begin
      n_fail++;
      $display("FAIL arb_empty_state: st=%0d required 1", fsm_state);
    end
    cnt[0] = 0;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      if (fsm_state !== 2'd0 || grant_vld !== 1'b0 || rel_pulse !== 1'b0 || rd_en !== '0) bad = 1'b1;
    end
    #2;
    n_cmp++;
    if (bad || pulse_q.size() !== 0 || rel_count !== 0) begin
      n_fail++;
      $display("FAIL arb_empty_idle: bad=%b pulses=%0d rels=%0d required 0 0 0",
               bad, pulse_q.size(), rel_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_fail = 0; viol = 0; rel_count = 0;
    test_reset();
    test_two_frames();
    test_rotation();
    test_burst_limit();
    test_stall();
    test_reset_mid_burst();
    test_arb_empty();
    n_cmp++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL rd_en_legal: illegal pulses=%0d required 0", viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
